// File: rtl/ddr_req_arbiter_if.sv
// Request/command bundle between the DDR requesters, the round-robin arbiter and
// the DDR burst controller.
//   slave  : arbiter view. It takes in the requests, addresses, lengths and burst
//            finishes, and drives the burst command, grant, done, busy and error.
//   master : environment view. Requesters and the burst controller drive the
//            inputs and observe the arbiter outputs.
interface ddr_req_arbiter_if #(
    parameter int unsigned DDR_ADDR_WIDTH = 28
);
    logic                      ddr_init_done;
    logic [3:0]                req_vec;
    logic [DDR_ADDR_WIDTH-1:0] isa_addr;
    logic [9:0]                isa_len;
    logic [DDR_ADDR_WIDTH-1:0] data_rd_addr;
    logic [DDR_ADDR_WIDTH-1:0] jmp_addr;
    logic [DDR_ADDR_WIDTH-1:0] data_wr_addr;
    logic                      rd_burst_finish;
    logic                      wr_burst_finish;
    logic                      rd_burst_req;
    logic                      wr_burst_req;
    logic [DDR_ADDR_WIDTH-1:0] burst_addr;
    logic [9:0]                burst_len;
    logic [3:0]                grant_onehot;
    logic [3:0]                done_onehot;
    logic                      busy;
    logic                      timeout_err;

    modport slave (
        input  ddr_init_done, req_vec, isa_addr, isa_len, data_rd_addr, jmp_addr,
               data_wr_addr, rd_burst_finish, wr_burst_finish,
        output rd_burst_req, wr_burst_req, burst_addr, burst_len, grant_onehot,
               done_onehot, busy, timeout_err
    );

    modport master (
        output ddr_init_done, req_vec, isa_addr, isa_len, data_rd_addr, jmp_addr,
               data_wr_addr, rd_burst_finish, wr_burst_finish,
        input  rd_burst_req, wr_burst_req, burst_addr, burst_len, grant_onehot,
               done_onehot, busy, timeout_err
    );
endinterface

// File: rtl/ddr_req_arbiter.sv
// Round-robin arbiter and sequencer in front of the DDR burst controller.
// Four level-held requesters are served: 0 ISA read, 1 data read, 2 jump-address
// read and 3 data store. One burst command is issued at a time and held until
// the matching finish arrives. The winner then gets a one-cycle done pulse. A
// watchdog aborts a burst that never finishes and sets a sticky error flag.
// Ports:
//   mem_clk : clock
//   rst     : asynchronous active-high reset
//   bus     : ddr_req_arbiter_if.slave, which carries the requests and the command
//             and status signals
module ddr_req_arbiter #(
    parameter int unsigned DDR_ADDR_WIDTH = 28,
    parameter int unsigned DATA_RD_LEN    = 17,
    parameter int unsigned DATA_WR_LEN    = 16,
    parameter int unsigned WR_ADDR_OFFSET = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input logic              mem_clk,
    input logic              rst,
    ddr_req_arbiter_if.slave bus
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                    state_q;
    logic [1:0]                last_idx_q;
    logic [1:0]                win_q;
    logic [CntW-1:0]           cnt_q;
    logic                      rd_req_q;
    logic                      wr_req_q;
    logic [DDR_ADDR_WIDTH-1:0] addr_q;
    logic [9:0]                len_q;
    logic [3:0]                grant_q;
    logic [3:0]                done_q;
    logic                      busy_q;
    logic                      timeout_err_q;

    logic                      found;
    logic [1:0]                win_idx;
    logic [1:0]                cand;
    logic [DDR_ADDR_WIDTH-1:0] cmd_addr;
    logic [9:0]                cmd_len;
    logic                      cmd_wr;
    logic                      fin_match;
    logic                      timeout_hit;

    // Search starts one past the last winner, so the last winner has the lowest priority.
    always_comb begin
        found   = 1'b0;
        win_idx = 2'd0;
        cand    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_idx_q + 2'(k);
            if (!found && bus.req_vec[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        cmd_addr = '0;
        cmd_len  = '0;
        cmd_wr   = 1'b0;
        case (win_idx)
            2'd0: begin
                cmd_addr = bus.isa_addr;
                cmd_len  = bus.isa_len;
            end
            2'd1: begin
                cmd_addr = bus.data_rd_addr;
                cmd_len  = 10'(DATA_RD_LEN);
            end
            2'd2: begin
                cmd_addr = bus.jmp_addr;
                cmd_len  = 10'd1;
            end
            default: begin
                // The sum wraps at the address width.
                cmd_addr = bus.data_wr_addr + DDR_ADDR_WIDTH'(WR_ADDR_OFFSET);
                cmd_len  = 10'(DATA_WR_LEN);
                cmd_wr   = 1'b1;
            end
        endcase
    end

    // Only the finish that matches the command type ends the burst.
    assign fin_match   = (win_q == 2'd3) ? bus.wr_burst_finish : bus.rd_burst_finish;
    assign timeout_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            last_idx_q    <= 2'd3;
            win_q         <= 2'd0;
            cnt_q         <= '0;
            rd_req_q      <= 1'b0;
            wr_req_q      <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            grant_q       <= '0;
            done_q        <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.ddr_init_done && found) begin
                        state_q  <= StBusy;
                        win_q    <= win_idx;
                        grant_q  <= 4'(1) << win_idx;
                        addr_q   <= cmd_addr;
                        len_q    <= cmd_len;
                        rd_req_q <= !cmd_wr;
                        wr_req_q <= cmd_wr;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                    end
                end
                StBusy: begin
                    // A finish on the same edge as the timeout counts as a normal completion.
                    if (fin_match || timeout_hit) begin
                        state_q    <= StDone;
                        rd_req_q   <= 1'b0;
                        wr_req_q   <= 1'b0;
                        grant_q    <= '0;
                        done_q     <= grant_q;
                        last_idx_q <= win_q;
                        if (!fin_match) begin
                            timeout_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    // This bubble gives the requester time to drop its request.
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.rd_burst_req = rd_req_q;
    assign bus.wr_burst_req = wr_req_q;
    assign bus.burst_addr   = addr_q;
    assign bus.burst_len    = len_q;
    assign bus.grant_onehot = grant_q;
    assign bus.done_onehot  = done_q;
    assign bus.busy         = busy_q;
    assign bus.timeout_err  = timeout_err_q;

endmodule
